debug_regbank_dumper: RTL

- Debug-unit side initiator for the register bank's debug read port.
- On command, walks addresses 0..BANK_DEPTH-1 and reads each register through the enable/read-enable/read-address interface.
- Captures each returned word and streams it byte-by-byte to the UART transmitter with a start/done handshake.
- Sits between the debug unit control FSM, the register bank and uart_tx.

---
 rtl/debug_regbank_dumper.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/debug_regbank_dumper.sv
// rtl/debug_regbank_dumper.sv - reads every bank register and streams it bytewise to uart_tx (optional DUMP_CHECKSUM_EN)
module debug_regbank_dumper #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 5,
    parameter int BANK_DEPTH = 32,
    parameter int NB_BYTE    = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    output logic               o_rb_enable,
    output logic               o_rb_read_enable,
    output logic [NB_ADDR-1:0] o_rb_read_address,
    input  logic [NB_DATA-1:0] i_rb_data,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_done
);

    localparam int BYTES  = NB_DATA / NB_BYTE;
    localparam int NB_CNT = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [NB_CNT-1:0]  LAST_BYTE = NB_CNT'(BYTES - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(BANK_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
        S_NEXT,
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0] acc_q, acc_d;
    logic               ck_phase_q, ck_phase_d;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
            acc_q      <= '0;
            ck_phase_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
`ifdef DUMP_CHECKSUM_EN
            acc_q      <= acc_d;
            ck_phase_q <= ck_phase_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
`ifdef DUMP_CHECKSUM_EN
        acc_d      = acc_q;
        ck_phase_d = ck_phase_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_REQ;
                    addr_d     = '0;
                    byte_cnt_d = '0;
`ifdef DUMP_CHECKSUM_EN
                    acc_d      = '0;
                    ck_phase_d = 1'b0;
`endif
                end
            end
            S_REQ: state_d = S_LATCH;
            S_LATCH: begin
                shift_d    = i_rb_data;
                byte_cnt_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
`ifdef DUMP_CHECKSUM_EN
                if (!ck_phase_q) begin
                    acc_d = acc_q ^ shift_q[NB_BYTE-1:0];
                end
`endif
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
                    if (ck_phase_q) begin
                        state_d = S_DONE;
                    end else
`endif
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = S_NEXT;
                    end else begin
                        shift_d    = shift_q >> NB_BYTE;
                        byte_cnt_d = byte_cnt_q + NB_CNT'(1);
                        state_d    = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
`ifdef DUMP_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d  = addr_q + NB_ADDR'(1);
                    state_d = S_REQ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            // The checksum byte reuses the SEND/WAIT_TX handshake from the shift register.
            S_CKSUM: begin
                shift_d    = NB_DATA'(acc_q);
                byte_cnt_d = '0;
                ck_phase_d = 1'b1;
                state_d    = S_SEND;
            end
`endif
            S_DONE: begin
                addr_d  = '0;
                shift_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rb_enable       = (state_q == S_REQ);
    assign o_rb_read_enable  = (state_q == S_REQ);
    assign o_rb_read_address = addr_q;
    assign o_tx_start        = (state_q == S_SEND);
    assign o_tx_data         = shift_q[NB_BYTE-1:0];
    assign o_busy            = (state_q != S_IDLE);
    assign o_done            = (state_q == S_DONE);

endmodule
